// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared OpenGPU register-file writeback definitions: port count, widths,
// writeback port identifiers and the writeback FSM state encoding.
package pkg_opengpu;
   localparam int NUM_WB_PORTS   = 3;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int DATA_WIDTH     = 32;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_LSU = 2'd1,
      WB_SFU = 2'd2
   } wb_port_e;

   typedef logic [0:0] rf_state_t;
   localparam rf_state_t ST_RUN  = 1'b0;
   localparam rf_state_t ST_INIT = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant to the first requester at or
// after the priority pointer; the pointer advances past the winner on accept.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         accept_i,
   output logic [N-1:0] gnt_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;
   int            sel;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      sel   = 0;
      // First pass: requesters at or above the pointer; second pass wraps.
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i >= int'(ptr_q))) begin
            found    = 1'b1;
            sel      = i;
            gnt_o[i] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i]) begin
            found    = 1'b1;
            sel      = i;
            gnt_o[i] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (accept_i && found) ptr_d = (sel == N-1) ? '0 : PW'(sel + 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grants one writeback port per
// cycle into a registered write stage, with a one-cycle context-init state.
module regfile_wb_arbiter
   import pkg_opengpu::*;
#(
   parameter int NUM_WB_PORTS = pkg_opengpu::NUM_WB_PORTS
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NUM_WB_PORTS-1:0]                       wb_valid,
   output logic [NUM_WB_PORTS-1:0]                       wb_ready,
   input  logic [NUM_WB_PORTS-1:0][REG_ADDR_WIDTH-1:0]   wb_addr,
   input  logic [NUM_WB_PORTS-1:0][DATA_WIDTH-1:0]       wb_data,
   input  logic                                          init_req,
   output logic                                          rf_we,
   output logic [REG_ADDR_WIDTH-1:0]                     rf_rd_addr,
   output logic [DATA_WIDTH-1:0]                         rf_rd_data,
   output logic                                          rf_init_context,
   output logic                                          init_done,
   output logic [15:0]                                   conflict_cnt
);
   rf_state_t                 state_q, state_d;
   logic [NUM_WB_PORTS-1:0]   gnt;
   logic                      grant_en, xfer, multi;
   logic [REG_ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic                      rf_we_q, init_done_q;
   logic [REG_ADDR_WIDTH-1:0] rf_addr_q;
   logic [DATA_WIDTH-1:0]     rf_data_q;
   logic [15:0]               conflict_q;

   // Init takes precedence over writes, so no grant is issued while it is pending.
   assign grant_en = (state_q == ST_RUN) && !init_req;

   rr_arbiter #(.N(NUM_WB_PORTS)) u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (wb_valid),
      .accept_i (grant_en),
      .gnt_o    (gnt)
   );

   assign wb_ready = grant_en ? gnt : '0;
   assign xfer     = |wb_ready;
   assign multi    = $countones(wb_valid) > 1;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_WB_PORTS; i++) begin
         if (wb_ready[i]) begin
            sel_addr = wb_addr[i];
            sel_data = wb_data[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN) begin
         if (init_req) state_d = ST_INIT;
      end else begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         rf_we_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_data_q   <= '0;
         init_done_q <= 1'b0;
         conflict_q  <= '0;
      end else begin
         state_q     <= state_d;
         // Writes to register 0 are accepted but discarded.
         rf_we_q     <= xfer && (sel_addr != '0);
         init_done_q <= (state_q == ST_INIT);
         if (xfer) begin
            rf_addr_q <= sel_addr;
            rf_data_q <= sel_data;
         end
         if (multi && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
      end
   end

   assign rf_we           = rf_we_q;
   assign rf_rd_addr      = rf_addr_q;
   assign rf_rd_data      = rf_data_q;
   assign rf_init_context = (state_q == ST_INIT);
   assign init_done       = init_done_q;
   assign conflict_cnt    = conflict_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_regfile_wb_arbiter;
   import pkg_opengpu::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       wb_valid, wb_ready;
   logic [2:0][4:0]  wb_addr;
   logic [2:0][31:0] wb_data;
   logic             init_req;
   logic             rf_we, rf_init_context, init_done;
   logic [4:0]       rf_rd_addr;
   logic [31:0]      rf_rd_data;
   logic [15:0]      conflict_cnt;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state
   int          m_ptr, m_cnt;
   bit          m_init, m_we, m_done;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [2:0]  ready_s;

   typedef struct {
      logic [2:0]       valid;
      logic [2:0][4:0]  addr;
      logic [2:0][31:0] data;
      logic             init;
      logic [2:0]       exp_ready;
      logic             exp_we;
      logic [4:0]       exp_addr;
      logic [31:0]      exp_data;
   } vec_t;
   vec_t tbl[6];

   regfile_wb_arbiter #(.NUM_WB_PORTS(3)) dut (
      .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_data(wb_data), .init_req(init_req),
      .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .rf_init_context(rf_init_context), .init_done(init_done),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] v, input logic [2:0][4:0] a,
                               input logic [2:0][31:0] d, input logic in,
                               input logic [2:0] er, input logic ew,
                               input logic [4:0] ea, input logic [31:0] ed);
      vec_t r;
      r.valid = v; r.addr = a; r.data = d; r.init = in;
      r.exp_ready = er; r.exp_we = ew; r.exp_addr = ea; r.exp_data = ed;
      return r;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_cnt = 0; m_init = 0; m_we = 0; m_done = 0;
      m_addr = '0; m_data = '0;
   endtask

   // One clock of traffic: check ready before the edge, registered outputs after.
   task automatic cycle(input string tag);
      logic [2:0] er;
      int g;
      er = '0;
      g  = -1;
      @(negedge clk);
      if (!m_init && !init_req)
         for (int k = 0; k < 3; k++)
            if (g < 0 && wb_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      if (g >= 0) er[g] = 1'b1;
      ready_s = wb_ready;
      chk({tag, " ready"}, wb_ready, er);
      @(posedge clk);
      if ($countones(wb_valid) > 1 && m_cnt < 65535) m_cnt++;
      m_done = m_init;
      m_we   = 0;
      if (g >= 0) begin
         m_we   = (wb_addr[g] != 0);
         m_addr = wb_addr[g];
         m_data = wb_data[g];
         m_ptr  = (g + 1) % 3;
      end
      m_init = !m_init && init_req;
      #1;
      chk({tag, " rf_we"}, rf_we, m_we);
      chk({tag, " init_ctx"}, rf_init_context, m_init);
      chk({tag, " init_done"}, init_done, m_done);
      chk({tag, " conflict_cnt"}, conflict_cnt, m_cnt);
      if (m_we) begin
         chk({tag, " rf_addr"}, rf_rd_addr, m_addr);
         chk({tag, " rf_data"}, rf_rd_data, m_data);
      end
   endtask

   task automatic do_reset();
      wb_valid = '0; wb_addr = '0; wb_data = '0; init_req = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst rf_we", rf_we, 0);
      chk("rst rf_addr", rf_rd_addr, 0);
      chk("rst rf_data", rf_rd_data, 0);
      chk("rst init_ctx", rf_init_context, 0);
      chk("rst init_done", init_done, 0);
      chk("rst conflict_cnt", conflict_cnt, 0);
      chk("rst ready", wb_ready, 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   initial begin
      tbl[0] = mk(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 0, 3'b010, 1, 5'd5, 32'hDEADBEEF);
      tbl[1] = mk(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 0, 3'b001, 0, 5'd0, 32'h0);
      tbl[2] = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 0, 3'b010, 1, 5'd2, 32'hA1);
      tbl[3] = mk(3'b101, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 0, 3'b100, 1, 5'd3, 32'hA2);
      tbl[4] = mk(3'b000, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 0, 3'b000, 0, 5'd0, 32'h0);
      tbl[5] = mk(3'b011, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 0, 3'b001, 1, 5'd1, 32'hA0);

      rst_n = 0;
      do_reset();

      for (int i = 0; i < 6; i++) begin
         wb_valid = tbl[i].valid; wb_addr = tbl[i].addr;
         wb_data = tbl[i].data;   init_req = tbl[i].init;
         cycle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl ready", i), ready_s, tbl[i].exp_ready);
         chk($sformatf("vec%0d tbl we", i), rf_we, tbl[i].exp_we);
         if (tbl[i].exp_we) begin
            chk($sformatf("vec%0d tbl addr", i), rf_rd_addr, tbl[i].exp_addr);
            chk($sformatf("vec%0d tbl data", i), rf_rd_data, tbl[i].exp_data);
         end
      end
      chk("vec tbl conflict_cnt", conflict_cnt, 16'd3);

      // Contention from reset: strict 0,1,2 rotation
      do_reset();
      wb_valid = 3'b111; wb_addr = {5'd3, 5'd2, 5'd1}; wb_data = {32'hC2, 32'hC1, 32'hC0};
      for (int k = 0; k < 3; k++) begin
         logic [2:0] one;
         one = 3'b001 << k;
         cycle("cont");
         chk($sformatf("cont grant%0d", k), ready_s, one);
      end
      chk("cont conflict_cnt", conflict_cnt, 16'd3);

      // Init versus simultaneous write
      do_reset();
      init_req = 1; wb_valid = 3'b100; wb_addr = {5'd9, 5'd0, 5'd0}; wb_data = {32'h55, 32'h0, 32'h0};
      cycle("ivw0");
      chk("ivw0 ready", ready_s, 3'b000);
      chk("ivw0 ctx", rf_init_context, 1);
      chk("ivw0 we", rf_we, 0);
      init_req = 0;
      cycle("ivw1");
      chk("ivw1 ready", ready_s, 3'b000);
      chk("ivw1 done", init_done, 1);
      chk("ivw1 ctx", rf_init_context, 0);
      cycle("ivw2");
      chk("ivw2 ready", ready_s, 3'b100);
      chk("ivw2 we", rf_we, 1);
      chk("ivw2 addr", rf_rd_addr, 5'd9);
      chk("ivw2 done", init_done, 0);

      // init_req held through INIT and the init_done cycle re-enters INIT
      do_reset();
      init_req = 1;
      cycle("hold0");
      cycle("hold1");
      chk("hold1 done", init_done, 1);
      cycle("hold2");
      chk("hold2 ctx", rf_init_context, 1);
      init_req = 0;
      cycle("hold3");

      // Reset asserted during INIT
      do_reset();
      init_req = 1;
      cycle("rdi0");
      init_req = 0;
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("rdi ctx", rf_init_context, 0);
      chk("rdi we", rf_we, 0);
      chk("rdi done", init_done, 0);
      chk("rdi ready", wb_ready, 0);
      @(posedge clk);
      #1;
      chk("rdi done2", init_done, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      @(posedge clk);
      #1;
      chk("rdi done3", init_done, 0);
      chk("rdi ctx3", rf_init_context, 0);
      wb_valid = 3'b111; wb_addr = {5'd3, 5'd2, 5'd1}; wb_data = {32'hD2, 32'hD1, 32'hD0};
      cycle("rdi_rr");
      chk("rdi_rr port0 first", ready_s, 3'b001);

      // Reset while a write is pending for the next cycle
      do_reset();
      wb_valid = 3'b010; wb_addr = {5'd0, 5'd7, 5'd0}; wb_data = {32'h0, 32'h77, 32'h0};
      @(negedge clk);
      chk("pend ready", wb_ready, 3'b010);
      #1 rst_n = 0;
      @(posedge clk);
      #1;
      chk("pend we", rf_we, 0);
      wb_valid = '0;
      @(negedge clk);
      rst_n = 1;
      model_reset();
      @(posedge clk);
      #1;
      chk("pend we2", rf_we, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         wb_valid = 3'($urandom);
         init_req = ($urandom_range(0, 9) == 0);
         for (int p = 0; p < 3; p++) begin
            wb_addr[p] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            wb_data[p] = $urandom;
         end
         cycle("rand");
      end

      // Saturation of the conflict counter
      do_reset();
      wb_valid = 3'b111;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat FFFE", conflict_cnt, 16'hFFFE);
      @(posedge clk);
      #1;
      chk("sat FFFF", conflict_cnt, 16'hFFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("sat hold", conflict_cnt, 16'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
